// File: rtl/rain_frame_sequencer.sv
// Frame/palette sequencer for the glyph-rain animation, running in the pixel clock domain.
// Optional macro RAIN_SEQ_REVERSE_EN adds a 'reverse' input that counts frames down while in RUN.
module rain_frame_sequencer #(
  parameter int FRAME_W   = 10,
  parameter int PAL_SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync_in,
  input  logic               pause,
  input  logic               step,
  input  logic [1:0]         speed,
  input  logic               pal_auto,
  input  logic [1:0]         pal_manual,
`ifdef RAIN_SEQ_REVERSE_EN
  input  logic               reverse,
`endif
  output logic [FRAME_W-1:0] frame,
  output logic               intro_done,
  output logic [1:0]         pal_sel,
  output logic               frame_tick,
  output logic               paused
);

  typedef enum logic [1:0] {ST_INTRO, ST_RUN, ST_PAUSED} state_t;

  localparam logic [FRAME_W-1:0] FRAME_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};
  localparam logic [FRAME_W-1:0] FRAME_LAST = {FRAME_W{1'b1}};

  state_t             r_state;
  state_t             w_nextState;
  logic               r_vsyncD;
  logic               r_stepD;
  logic [2:0]         r_prescaler;
  logic [2:0]         w_nextPrescaler;
  logic               r_stepPend;
  logic               w_nextStepPend;
  logic [FRAME_W-1:0] r_frame;
  logic [FRAME_W-1:0] w_frameNext;
  logic               r_introDone;
  logic [1:0]         r_palSel;
  logic               r_frameTick;
  logic               w_vrise;
  logic               w_srise;
  logic               w_advance;
  logic               w_decrement;
  logic               w_wrap;
  logic               w_palHit;
  logic [2:0]         w_limit;

  assign w_vrise = vsync_in & ~r_vsyncD;
  assign w_srise = step & ~r_stepD;

`ifdef RAIN_SEQ_REVERSE_EN
  assign w_decrement = reverse & (r_state == ST_RUN);
`else
  assign w_decrement = 1'b0;
`endif

  assign w_frameNext = w_decrement ? (r_frame - FRAME_ONE) : (r_frame + FRAME_ONE);
  // Only an upward wrap from all-ones ends the intro; reverse wraps never do.
  assign w_wrap      = ~w_decrement & (r_frame == FRAME_LAST);
  assign w_palHit    = w_decrement ? (&w_frameNext[PAL_SHIFT-1:0])
                                   : (~|w_frameNext[PAL_SHIFT-1:0]);

  always_comb begin
    w_limit = 3'd0;
    case (speed)
      2'd0:    w_limit = 3'd0;
      2'd1:    w_limit = 3'd1;
      2'd2:    w_limit = 3'd3;
      default: w_limit = 3'd7;
    endcase
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextPrescaler = r_prescaler;
    w_nextStepPend  = r_stepPend;
    w_advance       = 1'b0;
    case (r_state)
      ST_INTRO, ST_RUN: begin
        if (w_vrise) begin
          if (pause) begin
            w_nextState = ST_PAUSED;
          end else if (r_prescaler == w_limit) begin
            w_advance       = 1'b1;
            w_nextPrescaler = 3'd0;
          end else if (r_prescaler > w_limit) begin
            w_nextPrescaler = 3'd0;
          end else begin
            w_nextPrescaler = r_prescaler + 3'd1;
          end
        end
      end
      ST_PAUSED: begin
        // A step edge in the same cycle as vsync is consumed by that vsync.
        w_nextStepPend = r_stepPend | w_srise;
        if (w_vrise) begin
          if (!pause) begin
            w_nextState    = r_introDone ? ST_RUN : ST_INTRO;
            w_nextStepPend = 1'b0;
          end else if (w_nextStepPend) begin
            w_advance      = 1'b1;
            w_nextStepPend = 1'b0;
          end
        end
      end
      default: w_nextState = ST_INTRO;
    endcase
    if (w_advance && w_wrap && (r_state == ST_INTRO)) w_nextState = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_INTRO;
      r_vsyncD    <= 1'b1;
      r_stepD     <= 1'b1;
      r_prescaler <= 3'd0;
      r_stepPend  <= 1'b0;
      r_frame     <= '0;
      r_introDone <= 1'b0;
      r_palSel    <= 2'd0;
      r_frameTick <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_vsyncD    <= vsync_in;
      r_stepD     <= step;
      r_prescaler <= w_nextPrescaler;
      r_stepPend  <= w_nextStepPend;
      r_frameTick <= w_advance;
      if (w_advance) r_frame <= w_frameNext;
      if (w_advance && w_wrap) r_introDone <= 1'b1;
      if (!pal_auto) r_palSel <= pal_manual;
      else if (w_advance && w_palHit) r_palSel <= r_palSel + 2'd1;
    end
  end

  assign frame      = r_frame;
  assign intro_done = r_introDone;
  assign pal_sel    = r_palSel;
  assign frame_tick = r_frameTick;
  assign paused     = (r_state == ST_PAUSED);

endmodule

// File: tb/tb_rain_frame_sequencer.sv
// Directed self-checking bench for rain_frame_sequencer: frame advance, speed
// prescaling, intro wrap, pause/step, palette scheduling and mid-run reset.
module tb_rain_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync_in = 1'b1;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       pal_auto = 1'b0;
  logic [1:0] pal_manual = 2'd0;
  logic [9:0] frame;
  logic       intro_done;
  logic [1:0] pal_sel;
  logic       frame_tick;
  logic       paused;

  int checkCount = 0;
  int errorCount = 0;
  int tickCount = 0;
  int doubleTick = 0;
  int tickBase;
  logic prevTick = 1'b0;

  always #5 clk = ~clk;

  rain_frame_sequencer #(.FRAME_W(10), .PAL_SHIFT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync_in   (vsync_in),
    .pause      (pause),
    .step       (step),
    .speed      (speed),
    .pal_auto   (pal_auto),
    .pal_manual (pal_manual),
`ifdef RAIN_SEQ_REVERSE_EN
    .reverse    (1'b0),
`endif
    .frame      (frame),
    .intro_done (intro_done),
    .pal_sel    (pal_sel),
    .frame_tick (frame_tick),
    .paused     (paused)
  );

  // Counts tick pulses and flags any pulse that stays high two cycles running.
  always @(negedge clk) begin
    if (frame_tick) tickCount = tickCount + 1;
    if (frame_tick && prevTick) doubleTick = doubleTick + 1;
    prevTick = frame_tick;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle reset with vsync held high; returns aligned to a negedge.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    vsync_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Low for one edge then high: the following edge sees a rise.
  task automatic applyStimulus(input int rises);
    for (int i = 0; i < rises; i++) begin
      vsync_in = 1'b0;
      @(negedge clk);
      vsync_in = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic stepPulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: observed 0, expected 1");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Reset values and no advance on release with vsync high.
    doReset();
    checkOutput("reset_frame", 32'(frame), 0);
    checkOutput("reset_intro", 32'(intro_done), 0);
    checkOutput("reset_pal", 32'(pal_sel), 0);
    checkOutput("reset_tick", 32'(frame_tick), 0);
    checkOutput("reset_paused", 32'(paused), 0);
    @(negedge clk);
    checkOutput("release_frame", 32'(frame), 0);
    checkOutput("release_tick", 32'(frame_tick), 0);
    #1 tickBase = tickCount;

    // Speed 0: three rises, three single-cycle ticks.
    @(negedge clk);
    applyStimulus(1);
    checkOutput("tick_after_rise", 32'(frame_tick), 1);
    applyStimulus(2);
    checkOutput("speed0_frame", 32'(frame), 3);
    @(negedge clk);
    #1;
    checkOutput("tick_count", 32'(tickCount - tickBase), 3);
    checkOutput("tick_width", 32'(doubleTick), 0);

    // Prescaler: speed 2 then speed 3.
    doReset();
    speed = 2'd2;
    applyStimulus(12);
    checkOutput("speed2_frame", 32'(frame), 3);
    speed = 2'd3;
    applyStimulus(16);
    checkOutput("speed3_frame", 32'(frame), 5);

    // Intro completes on the 1024th advance.
    doReset();
    speed = 2'd0;
    applyStimulus(1023);
    checkOutput("pre_wrap_frame", 32'(frame), 1023);
    checkOutput("pre_wrap_intro", 32'(intro_done), 0);
    applyStimulus(1);
    checkOutput("wrap_frame", 32'(frame), 0);
    checkOutput("wrap_intro", 32'(intro_done), 1);
    applyStimulus(1);
    checkOutput("run_frame", 32'(frame), 1);
    checkOutput("run_intro_sticky", 32'(intro_done), 1);

    // Pause, steps, simultaneous step+vsync, resume.
    pause = 1'b1;
    applyStimulus(1);
    checkOutput("pause_enter", 32'(paused), 1);
    checkOutput("pause_no_adv", 32'(frame), 1);
    applyStimulus(4);
    checkOutput("pause_hold", 32'(frame), 1);
    stepPulse();
    stepPulse();
    stepPulse();
    checkOutput("step_pending_hold", 32'(frame), 1);
    applyStimulus(2);
    checkOutput("step_once", 32'(frame), 2);
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checkOutput("step_same_cycle", 32'(frame), 3);
    pause = 1'b0;
    applyStimulus(1);
    checkOutput("resume_no_adv", 32'(frame), 3);
    checkOutput("resume_paused", 32'(paused), 0);
    applyStimulus(1);
    checkOutput("resume_adv", 32'(frame), 4);

    // Reset while paused with a step pending.
    pause = 1'b1;
    applyStimulus(1);
    stepPulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pause = 1'b0;
    checkOutput("midrst_frame", 32'(frame), 0);
    checkOutput("midrst_intro", 32'(intro_done), 0);
    checkOutput("midrst_paused", 32'(paused), 0);
    checkOutput("midrst_tick", 32'(frame_tick), 0);
    applyStimulus(1);
    checkOutput("midrst_adv", 32'(frame), 1);
    checkOutput("midrst_adv_intro", 32'(intro_done), 0);

    // Auto palette and manual override.
    pal_auto = 1'b1;
    doReset();
    applyStimulus(255);
    checkOutput("pal_255", 32'(pal_sel), 0);
    applyStimulus(1);
    checkOutput("pal_256", 32'(pal_sel), 1);
    applyStimulus(256);
    checkOutput("pal_512", 32'(pal_sel), 2);
    pal_auto = 1'b0;
    pal_manual = 2'd3;
    @(negedge clk);
    checkOutput("pal_manual", 32'(pal_sel), 3);
    pal_auto = 1'b1;
    @(negedge clk);
    checkOutput("pal_auto_keep", 32'(pal_sel), 3);
    applyStimulus(256);
    checkOutput("pal_768_frame", 32'(frame), 768);
    checkOutput("pal_768", 32'(pal_sel), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
